// File: rtl/box_pkg.sv
// Shared defaults, state encoding and sizing helpers for the box-sum block.
package box_pkg;

  localparam int W_SUM_DEF    = 10;
  localparam int ROW_SIZE_DEF = 4;
  localparam int BOX_DEF      = 2;
  localparam int CNT_W        = $clog2(ROW_SIZE_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_delay_line.sv
// Circular sample delay: dout is the sample written DEPTH enables ago.
module int_delay_line #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
    end else if (enable) begin
      r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
    end
  end

  // Contents are never cleared; stale entries are masked by the caller.
  always_ff @(posedge clock) begin
    if (enable) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Read-before-write: the slot about to be overwritten is the oldest.
  assign dout = r_mem[r_wptr];

endmodule

// File: rtl/box_sum.sv
// Streaming BOX x BOX box sum from a raster-order integral image,
// one result per accepted sample with one cycle of latency.
module box_sum
  import box_pkg::*;
#(
  parameter int W_SUM    = W_SUM_DEF,
  parameter int ROW_SIZE = ROW_SIZE_DEF,
  parameter int BOX      = BOX_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W_SUM-1:0] in_sample,
  output logic             out_valid,
  output logic [W_SUM-1:0] out_sum,
  output logic             out_last
);

  localparam int CW    = cnt_w(ROW_SIZE);
  localparam int DEPTH = BOX * ROW_SIZE;
  localparam logic [CW:0]   BOX_C = (CW + 1)'(BOX);
  localparam logic [CW-1:0] LAST  = CW'(ROW_SIZE - 1);

  state_e r_state;
  state_e w_state_nx;

  logic [CW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic             r_valid;
  logic [W_SUM-1:0] r_sum;
  logic             r_last;

  logic [W_SUM-1:0] r_cur_d [BOX];
  logic [W_SUM-1:0] r_up_d  [BOX];

  logic [W_SUM-1:0] w_up;
  logic [W_SUM-1:0] w_left;
  logic [W_SUM-1:0] w_diag;
  logic [W_SUM-1:0] w_t_up;
  logic [W_SUM-1:0] w_t_left;
  logic [W_SUM-1:0] w_t_diag;
  logic [W_SUM-1:0] w_sum;
  logic             w_row_ok;
  logic             w_col_ok;
  logic             w_col_end;
  logic             w_row_end;
  logic             w_frame_end;

  int_delay_line #(
    .WIDTH (W_SUM),
    .DEPTH (DEPTH)
  ) u_row_delay (
    .clock  (clock),
    .reset  (reset),
    .enable (in_valid),
    .din    (in_sample),
    .dout   (w_up)
  );

  assign w_left      = r_cur_d[BOX-1];
  assign w_diag      = r_up_d[BOX-1];
  assign w_row_ok    = {1'b0, r_row} >= BOX_C;
  assign w_col_ok    = {1'b0, r_col} >= BOX_C;
  assign w_col_end   = r_col == LAST;
  assign w_row_end   = r_row == LAST;
  assign w_frame_end = w_col_end & w_row_end;

  // Counter position masks out-of-frame and previous-frame history.
  assign w_t_up   = w_row_ok ? w_up : '0;
  assign w_t_left = w_col_ok ? w_left : '0;
  assign w_t_diag = (w_row_ok & w_col_ok) ? w_diag : '0;
  assign w_sum    = in_sample - w_t_up - w_t_left + w_t_diag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BOX; i++) begin
        r_cur_d[i] <= '0;
        r_up_d[i]  <= '0;
      end
    end else if (in_valid) begin
      r_cur_d[0] <= in_sample;
      r_up_d[0]  <= w_up;
      for (int i = 1; i < BOX; i++) begin
        r_cur_d[i] <= r_cur_d[i-1];
        r_up_d[i]  <= r_up_d[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (in_valid) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid && !w_frame_end) begin
          w_state_nx = STREAM;
        end
      end
      STREAM: begin
        if (in_valid && w_frame_end) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_last <= w_frame_end;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_sum   = r_sum;
  assign out_last  = r_last;

endmodule

// File: tb/tb_box_sum.sv
// Randomised scoreboard bench for box_sum against a pixel-level box-sum model.
module tb_box_sum;

  localparam int W = 10;
  localparam int N = 4;
  localparam int B = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_sample = '0;
  logic         out_valid;
  logic [W-1:0] out_sum;
  logic         out_last;

  always #5 clock = ~clock;

  box_sum #(
    .W_SUM    (W),
    .ROW_SIZE (N),
    .BOX      (B)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_last  (out_last)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] hold_sum = '0;
  logic         hold_last = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      check("reset_valid", int'(out_valid), 0);
      check("reset_sum", int'(out_sum), 0);
      check("reset_last", int'(out_last), 0);
      hold_sum  = '0;
      hold_last = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("sum", int'(out_sum), int'(e.sum));
        check("last", int'(out_last), int'(e.last));
        check("latency_cycle", cyc, e.cyc);
        hold_sum  = e.sum;
        hold_last = e.last;
      end
    end else begin
      check("hold_sum", int'(out_sum), int'(hold_sum));
      check("hold_last", int'(out_last), int'(hold_last));
    end
  end

  task automatic idle();
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] e,
                      input logic l);
    @(posedge clock);
    #1;
    in_valid  = 1'b1;
    in_sample = s;
    q.push_back('{sum: e, last: l, cyc: cyc + 1});
  endtask

  // mode 0: all ones, 1: random pixels, 2: all 255.
  // gap 0: none, 1: idle after every 2nd sample, 2: random idles.
  task automatic run_frame(input int mode, input int gap, input int npix);
    int pix [N][N];
    int ones [16] = '{1, 2, 2, 2, 2, 4, 4, 4, 2, 4, 4, 4, 2, 4, 4, 4};
    int integ;
    int box;
    int r;
    int c;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pix[i][j] = (mode == 0) ? 1 :
                    (mode == 2) ? 255 : int'($urandom_range(0, 255));
      end
    end
    for (int k = 0; k < npix; k++) begin
      r = k / N;
      c = k % N;
      integ = 0;
      box = 0;
      for (int i = 0; i <= r; i++) begin
        for (int j = 0; j <= c; j++) begin
          integ += pix[i][j];
          if (i > r - B && j > c - B) box += pix[i][j];
        end
      end
      if (mode == 0) box = ones[k];
      send(W'(integ), W'(box), (r == N - 1) && (c == N - 1));
      if (gap == 1 && (k % 2) == 1) idle();
      if (gap == 2) begin
        repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) idle();
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    run_frame(0, 0, 16);
    run_frame(0, 0, 16);
    run_frame(0, 1, 16);
    idle();
    run_frame(0, 0, 7);
    idle();
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    run_frame(0, 0, 16);
    run_frame(2, 0, 16);
    repeat (20) run_frame(1, 2, 16);
    repeat (4) idle();

    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
